// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one multi-cycle memory port between the I-cache refill path and the
// D-cache miss/write-through path. Each granted access occupies the port for
// MEM_LATENCY cycles and is followed by a one-cycle done pulse to its requester.
//
// Build option: define MEM_ARB_RR_EN to alternate grants on simultaneous
// I/D requests (the side opposite the previous grant wins). Without it, D
// always wins a conflict.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int BLOCK_WORDS = 4,
    parameter int MEM_LATENCY = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             i_req,
    input  logic [WORD_SIZE-1:0]             i_addr,
    output logic                             i_done,
    output logic [WORD_SIZE*BLOCK_WORDS-1:0] i_rdata,
    input  logic                             d_req,
    input  logic                             d_we,
    input  logic [WORD_SIZE-1:0]             d_addr,
    input  logic [WORD_SIZE-1:0]             d_wdata,
    output logic                             d_done,
    output logic [WORD_SIZE*BLOCK_WORDS-1:0] d_rdata,
    output logic                             m_readM,
    output logic                             m_writeM,
    output logic [WORD_SIZE-1:0]             m_address,
    output logic [WORD_SIZE-1:0]             m_wdata,
    input  logic [WORD_SIZE*BLOCK_WORDS-1:0] m_rdata
);

    localparam int BLOCK_W = WORD_SIZE * BLOCK_WORDS;
    localparam int CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
    logic [WORD_SIZE-1:0] r_addr,   w_addr_nxt;
    logic                 r_we,     w_we_nxt;
    logic [WORD_SIZE-1:0] r_wdata,  w_wdata_nxt;
    logic                 r_readM,  w_readM_nxt;
    logic                 r_writeM, w_writeM_nxt;
    logic                 r_i_done, w_i_done_nxt;
    logic                 r_d_done, w_d_done_nxt;
    logic [BLOCK_W-1:0]   r_i_rdata, w_i_rdata_nxt;
    logic [BLOCK_W-1:0]   r_d_rdata, w_d_rdata_nxt;
    logic                 w_grant_d;

`ifdef MEM_ARB_RR_EN
    logic                 r_last_d, w_last_d_nxt;

    // Conflict resolution: the side that did not win last time gets the port.
    always_comb begin
        if (d_req && i_req) begin
            w_grant_d = ~r_last_d;
        end else begin
            w_grant_d = d_req;
        end
    end
`else
    // Conflict resolution: D always wins when it is requesting.
    always_comb begin
        w_grant_d = d_req;
    end
`endif

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_addr_nxt    = r_addr;
        w_we_nxt      = r_we;
        w_wdata_nxt   = r_wdata;
        w_readM_nxt   = 1'b0;
        w_writeM_nxt  = 1'b0;
        w_i_done_nxt  = 1'b0;
        w_d_done_nxt  = 1'b0;
        w_i_rdata_nxt = r_i_rdata;
        w_d_rdata_nxt = r_d_rdata;
`ifdef MEM_ARB_RR_EN
        w_last_d_nxt  = r_last_d;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    w_cnt_nxt = CNT_LOAD;
                    if (w_grant_d) begin
                        w_state_nxt  = ST_BUSY_D;
                        w_addr_nxt   = d_addr;
                        w_we_nxt     = d_we;
                        w_wdata_nxt  = d_wdata;
                        w_readM_nxt  = ~d_we;
                        w_writeM_nxt = d_we;
`ifdef MEM_ARB_RR_EN
                        w_last_d_nxt = 1'b1;
`endif
                    end else begin
                        w_state_nxt  = ST_BUSY_I;
                        w_addr_nxt   = i_addr;
                        w_we_nxt     = 1'b0;
                        w_readM_nxt  = 1'b1;
`ifdef MEM_ARB_RR_EN
                        w_last_d_nxt = 1'b0;
`endif
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (r_cnt == 4'd0) begin
                    // Last port cycle: m_rdata is valid now, capture it.
                    w_state_nxt = ST_DONE;
                    if (r_state == ST_BUSY_I) begin
                        w_i_rdata_nxt = m_rdata;
                        w_i_done_nxt  = 1'b1;
                    end else begin
                        w_d_done_nxt = 1'b1;
                        if (!r_we) begin
                            w_d_rdata_nxt = m_rdata;
                        end else begin
                            w_d_rdata_nxt = r_d_rdata;
                        end
                    end
                end else begin
                    // Reads strobe every busy cycle; writes only strobe once.
                    w_cnt_nxt   = r_cnt - 4'd1;
                    w_readM_nxt = ~r_we;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= {WORD_SIZE{1'b0}};
            r_we      <= 1'b0;
            r_wdata   <= {WORD_SIZE{1'b0}};
            r_readM   <= 1'b0;
            r_writeM  <= 1'b0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_i_rdata <= {BLOCK_W{1'b0}};
            r_d_rdata <= {BLOCK_W{1'b0}};
`ifdef MEM_ARB_RR_EN
            r_last_d  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_we      <= w_we_nxt;
            r_wdata   <= w_wdata_nxt;
            r_readM   <= w_readM_nxt;
            r_writeM  <= w_writeM_nxt;
            r_i_done  <= w_i_done_nxt;
            r_d_done  <= w_d_done_nxt;
            r_i_rdata <= w_i_rdata_nxt;
            r_d_rdata <= w_d_rdata_nxt;
`ifdef MEM_ARB_RR_EN
            r_last_d  <= w_last_d_nxt;
`endif
        end
    end

    assign i_done    = r_i_done;
    assign d_done    = r_d_done;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign m_readM   = r_readM;
    assign m_writeM  = r_writeM;
    assign m_address = r_addr;
    // The write bus is released whenever no write strobe is active.
    assign m_wdata   = r_writeM ? r_wdata : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Randomized bench for mem_port_arbiter. A transaction-level reference model
// (grant order, completion cycle, expected block contents from a shadow memory)
// predicts every observable result of each round of requests.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_done;
    logic [63:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        m_readM;
    logic        m_writeM;
    logic [15:0] m_address;
    wire  [15:0] m_wdata;
    logic [63:0] m_rdata;

    mem_port_arbiter #(
        .WORD_SIZE   (16),
        .BLOCK_WORDS (4),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .m_readM   (m_readM),
        .m_writeM  (m_writeM),
        .m_address (m_address),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata)
    );

    always #5 clk = ~clk;

    // Memory model seen by the DUT, plus a shadow copy owned by the reference model.
    logic [15:0] init_mem [0:255];
    logic [15:0] mem      [0:255];
    logic [15:0] ref_mem  [0:255];
    bit          mem_loaded = 1'b0;
    logic [7:0]  ma;

    // Memory model: loads its image on the first edge, then accepts strobed writes.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_mem[k];
            mem_loaded <= 1'b1;
        end else if (m_writeM) begin
            mem[m_address[7:0]] <= m_wdata;
        end
    end

    assign ma      = m_address[7:0];
    assign m_rdata = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [63:0] exp_i = 64'd0;
    logic [63:0] exp_d = 64'd0;
    bit          mdl_last_d = 1'b0;

    function automatic logic [63:0] block_of(input logic [15:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {ref_mem[b], ref_mem[b + 8'd1], ref_mem[b + 8'd2], ref_mem[b + 8'd3]};
    endfunction

    task automatic apply_d(input bit we, input logic [15:0] da, input logic [15:0] dw);
        if (we) ref_mem[da[7:0]] = dw;
        else    exp_d = block_of(da);
    endtask

    // One round: raise the chosen requests together and observe until both settle.
    task automatic run_round(input string tag, input bit ri, input bit rd, input bit we,
                             input logic [15:0] ia, input logic [15:0] da, input logic [15:0] dw);
        bit d_first;
        int t_i_exp, t_d_exp, t_i, t_d;
        int n_i, n_d, rd_cnt, wr_cnt, overlap, rd_exp, wr_exp;

        if (ri && rd) begin
`ifdef MEM_ARB_RR_EN
            d_first = !mdl_last_d;
`else
            d_first = 1'b1;
`endif
        end else begin
            d_first = rd;
        end

        t_i_exp = -1;
        t_d_exp = -1;
        if (ri && rd) begin
            if (d_first) begin t_d_exp = LAT + 1; t_i_exp = 2 * LAT + 3; end
            else         begin t_i_exp = LAT + 1; t_d_exp = 2 * LAT + 3; end
        end else if (ri) begin
            t_i_exp = LAT + 1;
        end else if (rd) begin
            t_d_exp = LAT + 1;
        end

        if (rd && d_first) apply_d(we, da, dw);
        if (ri) exp_i = block_of(ia);
        if (rd && !d_first) apply_d(we, da, dw);
        if (ri && rd) mdl_last_d = !d_first;
        else if (ri || rd) mdl_last_d = rd;

        rd_exp = LAT * ((ri ? 1 : 0) + ((rd && !we) ? 1 : 0));
        wr_exp = (rd && we) ? 1 : 0;

        @(negedge clk);
        i_req = ri; i_addr = ia; d_req = rd; d_we = we; d_addr = da; d_wdata = dw;
        t_i = -1; t_d = -1; n_i = 0; n_d = 0; rd_cnt = 0; wr_cnt = 0; overlap = 0;
        for (int k = 1; k <= 2 * LAT + 6; k++) begin
            @(negedge clk);
            if (m_readM)  rd_cnt++;
            if (m_writeM) wr_cnt++;
            if (m_readM && m_writeM) overlap++;
            if (i_done && d_done)    overlap++;
            if (i_done) begin n_i++; if (t_i < 0) t_i = k; i_req = 1'b0; end
            if (d_done) begin n_d++; if (t_d < 0) t_d = k; d_req = 1'b0; end
        end
        i_req = 1'b0;
        d_req = 1'b0;

        check_eq({tag, "_i_time"},  t_i,     t_i_exp);
        check_eq({tag, "_d_time"},  t_d,     t_d_exp);
        check_eq({tag, "_i_pulses"}, n_i,    (ri ? 1 : 0));
        check_eq({tag, "_d_pulses"}, n_d,    (rd ? 1 : 0));
        check_eq({tag, "_readM"},   rd_cnt,  rd_exp);
        check_eq({tag, "_writeM"},  wr_cnt,  wr_exp);
        check_eq({tag, "_overlap"}, overlap, 0);
        check_eq({tag, "_i_rdata"}, i_rdata, exp_i);
        check_eq({tag, "_d_rdata"}, d_rdata, exp_d);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) init_mem[k] = 16'($urandom);
        init_mem[0] = 16'h9023;
        init_mem[1] = 16'h0001;
        init_mem[2] = 16'hFFFF;
        init_mem[3] = 16'h0000;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_mem[k];

        reset_n = 1'b0;
        i_req = 1'b0; i_addr = 16'h0000;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        check_eq("rst_readM",   m_readM,   1'b0);
        check_eq("rst_writeM",  m_writeM,  1'b0);
        check_eq("rst_i_done",  i_done,    1'b0);
        check_eq("rst_d_done",  d_done,    1'b0);
        check_eq("rst_i_rdata", i_rdata,   64'd0);
        check_eq("rst_d_rdata", d_rdata,   64'd0);
        check_eq("rst_m_addr",  m_address, 16'h0000);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed: I block read of the preloaded block at address 0.
        run_round("t1", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        check_eq("t1_value", i_rdata, 64'h9023_0001_FFFF_0000);

        // Directed: D write then D read of the same block.
        run_round("t2w", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0010, 16'hBEEF);
        run_round("t2r", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000);
        check_eq("t2_word", d_rdata[63:48], 16'hBEEF);

        // Directed: simultaneous requests, then several conflicts in a row.
        run_round("t3", 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0030, 16'h0000);
        for (int r = 0; r < 4; r++)
            run_round("t4", 1'b1, 1'b1, 1'b0, 16'(r * 8), 16'(r * 8 + 4), 16'h0000);

        // Reset in the middle of an I read: abandoned with no done pulse.
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0040;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("t5_readM",   m_readM,  1'b0);
        check_eq("t5_writeM",  m_writeM, 1'b0);
        check_eq("t5_i_done",  i_done,   1'b0);
        check_eq("t5_i_rdata", i_rdata,  64'd0);
        check_eq("t5_d_rdata", d_rdata,  64'd0);
        i_req = 1'b0;
        reset_n = 1'b1;
        begin
            int dn;
            dn = 0;
            for (int k = 0; k < LAT + 3; k++) begin
                @(negedge clk);
                if (i_done || d_done) dn++;
            end
            check_eq("t5_no_done", dn, 0);
        end
        exp_i = 64'd0;
        exp_d = 64'd0;
        mdl_last_d = 1'b0;
        run_round("t5_fresh", 1'b1, 1'b0, 1'b0, 16'h0044, 16'h0000, 16'h0000);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            bit ri, rd, we;
            logic [15:0] ia, da, dw;
            ri = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (!ri && !rd) ri = 1'b1;
            we = 1'($urandom_range(0, 1));
            ia = 16'($urandom_range(0, 63) * 4);
            da = we ? 16'($urandom_range(0, 255)) : 16'($urandom_range(0, 63) * 4);
            dw = 16'($urandom);
            run_round("rnd", ri, rd, we, ia, da, dw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
